prio_encoder_queue: RTL
=======================

Name: prio_encoder_queue

Overview:
- Parametrised, registered successor to the 8-to-3 priority encoder.
- Captures requests from N lines into a sticky pending register and presents one winner at a time as a binary code.
- Output uses a valid/ready handshake. Fixed-priority (highest index wins) or round-robin selection; per-line masking; level or rising-edge capture.
- Sits between raw event/interrupt lines and a consumer that services one index per handshake.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, 3, code width; must equal ceil(log2(N)).
- EDGE, 0, 0 = level capture, 1 = rising-edge capture.
- RR, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  request lines.
- mask  input  N  1 = line ineligible for selection; still captured into pending.
- out_code  output  W  index of the presented request.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code when out_valid && out_ready.
- pending  output  N  current sticky pending register.
- overflow  output  1  one-cycle pulse: a capture hit an already-pending bit.

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=0, out_valid=0, out_code=0, overflow=0, req_q=0, rotation pointer ptr=N-1.
  - Applies mid-handshake; any presented code is dropped with no clear semantics.
- Capture vector:
  - cap = req when EDGE=0.
  - cap = req & ~req_q when EDGE=1, where req_q is req registered each cycle.
- Grant clear vector: clr = onehot(out_code) when out_valid && out_ready, else 0.
- Pending update: pending <= (pending & ~clr) | cap.
  - Capture and clear on the same bit in the same cycle: capture wins and the bit stays set (counts as a new event).
- overflow <= |(cap & pending & ~clr). Registered, high for one cycle per offending cycle.
- Eligible set: elig = pending & ~mask & ~clr.
- Selection, fixed (RR=0): highest set index of elig.
- Selection, round-robin (RR=1):
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; first set bit wins.
  - On each handshake of index g: ptr <= (g==0) ? N-1 : g-1, so g becomes lowest priority.
- Output FSM, two states:
  - IDLE (out_valid=0): if elig != 0, load out_code <= winner and go PRESENT (out_valid=1 next cycle). Otherwise stay.
  - PRESENT (out_valid=1): out_code and out_valid hold stable while out_ready=0. Later masking or arrival of a higher-priority request does NOT retract or change the presented code.
  - PRESENT on handshake: if elig (clr applied) != 0, load next winner same edge and stay PRESENT (back-to-back, one grant per cycle). Otherwise go IDLE and drop out_valid.
- Latency:
  - Level request at edge t sets pending at t; out_valid is high after edge t+1 when IDLE.
  - EDGE=1 gives the same latency, measured from the first edge where req=1 and req_q=0.
- Level mode: a line held high re-captures every cycle. After its grant it re-appears in pending the next cycle, and overflow pulses each cycle it is already pending.
- Width rules:
  - out_code is zero-extended index.
  - When N < 2^W, codes >= N are never produced.
  - Selection logic must be generated for any N via loop, not hand-unrolled.
- All-masked case: pending may be non-zero while out_valid stays 0. Unmasking makes out_valid rise on the following edge.

Test Plan:
- Fixed priority, N=8, EDGE=0, RR=0: pulse req=8'b0010_1100 for one cycle with out_ready=1 → codes 5, 3, 2 on consecutive cycles; then out_valid=0, pending=0.
- Backpressure: req=8'h81 pulse, out_ready=0 for 5 cycles → out_code=7 stable; then assert req[6] → out_code stays 7. Raise out_ready → sequence 7, 6, 0.
- Masking: pending=8'h90 with mask=8'h80 → code 4 only; pending[7] remains 1 and out_valid=0 afterwards. Clear mask → code 7 one cycle later.
- Round-robin, RR=1: req=8'hFF held (level), out_ready=1 → codes 7, 6, 5, ..., 0, 7 cyclic. overflow=1 from the second cycle on.
- Edge mode, EDGE=1: hold req[3]=1 for 10 cycles → exactly one grant of code 3. Drop and re-raise → second grant; overflow never asserts.
- Reset mid-operation: pending=8'hF0, out_valid=1, drive rst_n=0 for one edge → next cycle pending=0, out_valid=0, out_code=0, overflow=0; ptr restarts at 7.

Source files
------------

// File: rtl/prio_encoder_queue.sv
// Sticky-pending priority encoder: captures N request lines and presents one
// winning index at a time on a valid/ready handshake (fixed or round-robin).
module prio_encoder_queue #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int EDGE = 0,
  parameter int RR   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  state_e       state_q;
  logic [W-1:0] code_q;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] req_q;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;

  logic         handshake;
  logic [N-1:0] cap, clr, elig;
  logic [W-1:0] winner;
  logic         found;

  assign handshake = (state_q == S_PRESENT) && out_ready;
  assign cap       = (EDGE != 0) ? (req & ~req_q) : req;

  // NOTE: every variable written in always_comb gets a default before any
  // conditional update, otherwise synthesis infers a latch to hold it.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = handshake && (code_q == W'(i));
    end
  end

  // A capture on the bit being granted keeps it set: it is a fresh event.
  assign pending_d  = (pending_q & ~clr) | cap;
  assign overflow_d = |(cap & pending_q & ~clr);
  assign elig       = pending_q & ~mask & ~clr;
  assign found      = |elig;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (code_q == '0) ? W'(N - 1) : code_q - 1'b1;
    end
  end

  // Round-robin searches from the pointer as updated by this cycle's grant,
  // so the line just serviced is already lowest priority for the next pick.
  always_comb begin
    int           pos;
    logic [W-1:0] idx;
    winner = '0;
    pos    = 0;
    idx    = '0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) winner = W'(i);
      end
    end else begin
      for (int d = N - 1; d >= 0; d--) begin
        pos = (int'(ptr_d) >= d) ? int'(ptr_d) - d : int'(ptr_d) + N - d;
        idx = W'(pos);
        if (elig[idx]) winner = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      ptr_q      <= W'(N - 1);
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_q      <= req;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            code_q  <= winner;
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Without a handshake the presented code is frozen.
          if (out_ready) begin
            if (found) code_q <= winner;
            else       state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_code  = code_q;
  assign out_valid = (state_q == S_PRESENT);
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
